fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the write port of one async_fifo between NUM_REQ producers in the wclk domain.
//  Grants one requester at a time for a burst of up to MAX_BURST beats, ended early by req_last or by valid dropping.
//  Muxes the granted requester's data onto fifo_wdata and qualifies fifo_winc with the FIFO full flag.
//  Sits between producer blocks and the FIFO write port (winc/wdata/wfull).
// PARAMETERS
//  NUM_REQ    4  number of requesters, >=2
//  DATA_WIDTH 8  FIFO data width
//  MAX_BURST  4  max beats per grant, >=1
// PORTS
//  wclk         in   1                     write-domain clock, single clock for the whole block
//  wrst_n       in   1                     asynchronous active-low reset
//  req_valid    in   NUM_REQ               per-requester data valid
//  req_last     in   NUM_REQ               per-requester last beat of burst, sampled with valid
//  req_data     in   NUM_REQ*DATA_WIDTH    requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready    out  NUM_REQ               per-requester accept
//  fifo_winc    out  1                     to FIFO winc
//  fifo_wdata   out  DATA_WIDTH            to FIFO wdata
//  fifo_wfull   in   1                     from FIFO wfull
//  grant_valid  out  1                     a grant is held (state GRANT)
//  grant_id     out  $clog2(NUM_REQ)       index of the granted requester, valid when grant_valid=1
// BEHAVIOUR
//  Reset (async, wrst_n=0): state=IDLE, grant_valid=0, grant_id=0, rr_ptr=0, beat_cnt=0, req_ready=0, fifo_winc=0.
//  Handshake: a beat transfers on a wclk edge with req_valid[g] & req_ready[g], where g = grant_id.
//   Requesters hold valid/data/last stable until accepted.
//   req_ready does not depend on req_valid.
//  req_ready[i] = (state==GRANT) & (grant_id==i) & ~fifo_wfull. It is combinational.
//  fifo_winc = req_valid[g] & req_ready[g]. Never high while fifo_wfull=1.
//  fifo_wdata = req_data slice g.
//  FSM IDLE:
//   Combinationally picks the first requester with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   If one is found: next edge grant_id<=winner, beat_cnt<=0, state<=GRANT.
//   If none is found: stays IDLE.
//   Arbitration latency is 1 cycle: the first beat can transfer no earlier than the cycle after entering GRANT.
//  FSM GRANT, on a transfer:
//   If req_last[g]=1 or beat_cnt==MAX_BURST-1: release.
//   Otherwise beat_cnt<=beat_cnt+1.
//  FSM GRANT, no transfer:
//   If req_valid[g]=0: release.
//   Otherwise the grant is held with beat_cnt unchanged; this covers fifo_wfull stalls of any length.
//  Release: state<=IDLE, rr_ptr<=(g+1) mod NUM_REQ with wrap-around, beat_cnt<=0.
//   grant_valid falls on the next edge. One IDLE cycle separates consecutive grants.
//  fifo_wfull never causes a release. A burst stalled on full resumes with the same requester.
//  Simultaneous events:
//   Transfer with req_last=1 on beat MAX_BURST-1 is a single release.
//   fifo_wfull rising in the same cycle as valid is a stall, not a transfer.
//  beat_cnt width is $clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1.
//  Reset mid-burst: all outputs drop to their reset values immediately. The partial burst is abandoned.
//   Beats already written remain in the FIFO.
//  Non-granted requesters see req_ready=0 and must hold their requests.
// TESTING
//  1. Only req 0 valid; data 0x11,0x22,0x33; last on 0x33.
//     -> grant_id=0 one cycle after valid; fifo_winc high 3 consecutive cycles with wdata 0x11,0x22,0x33; then IDLE.
//  2. All 4 requesters continuously valid, no last, fifo_wfull=0.
//     -> grants 0,1,2,3,0 in order; exactly 4 beats each; 1 idle cycle between grants.
//  3. Req 1 bursting; fifo_wfull=1 for 5 cycles after beat 2.
//     -> req_ready/fifo_winc low for those 5 cycles; grant_id stays 1; beats 3-4 follow; 4 beats total.
//  4. Req 2 drops valid after 1 beat while req 3 is valid.
//     -> release, then req 3 granted after 1 IDLE cycle; rr_ptr wraps so the next search starts at 0.
//  5. wrst_n pulsed low mid-burst on req 1.
//     -> fifo_winc, req_ready, grant_valid 0 in the same cycle; after reset release, req 0 wins if valid.
//  6. Scoreboard over random valid/last/wfull:
//     -> FIFO receives every accepted beat in order per requester; no write while full; no grant exceeds MAX_BURST beats.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producers, the arbiter and the async FIFO write port.
// The master modport is the producer/FIFO side; the slave modport is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_winc;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic                          fifo_wfull;
  logic                          grant_valid;
  logic [IDW-1:0]                grant_id;

  modport master (
    output req_valid, req_last, req_data, fifo_wfull,
    input  req_ready, fifo_winc, fifo_wdata, grant_valid, grant_id
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_wfull,
    output req_ready, fifo_winc, fifo_wdata, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among NUM_REQ producers.
// A grant lasts up to MAX_BURST beats and ends early on req_last or when valid drops.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);
  localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q;
  logic [IDW-1:0] grant_id_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [BCW-1:0] beat_cnt_q;

  logic           found_d;
  logic [IDW-1:0] winner_d;
  logic [IDW:0]   cand;
  logic           granted;
  logic           g_valid;
  logic           g_last;
  logic           xfer;
  logic           burst_done;
  logic [IDW-1:0] next_ptr;

  // First valid requester found walking upward from rr_ptr with wrap-around.
  always_comb begin
    found_d  = 1'b0;
    winner_d = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!found_d && bus.req_valid[cand[IDW-1:0]]) begin
        found_d  = 1'b1;
        winner_d = cand[IDW-1:0];
      end
    end
  end

  assign granted    = (state_q == GRANT);
  assign g_valid    = bus.req_valid[grant_id_q];
  assign g_last     = bus.req_last[grant_id_q];
  assign xfer       = granted & g_valid & ~bus.fifo_wfull;
  assign burst_done = g_last | (beat_cnt_q == LAST_BEAT);
  assign next_ptr   = (grant_id_q == LAST_ID) ? '0 : grant_id_q + IDW'(1);

  // Ready is independent of valid so producers never see a combinational loop.
  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        bus.req_ready[i] = granted & ~bus.fifo_wfull;
        bus.fifo_wdata   = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.fifo_winc   = xfer;
  assign bus.grant_valid = granted;
  assign bus.grant_id    = grant_id_q;

  // A full FIFO only stalls the burst; the grant is dropped on last beat, burst limit or valid loss.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_id_q <= winner_d;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (xfer && !burst_done) begin
            beat_cnt_q <= beat_cnt_q + BCW'(1);
          end else if (xfer || !g_valid) begin
            state_q    <= IDLE;
            rr_ptr_q   <= next_ptr;
            beat_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a transaction-level model
// of grant ownership, burst length and round-robin order.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  typedef logic [DATA_WIDTH:0] beat_t;

  logic wclk = 1'b0;
  logic wrst_n;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (bus)
  );

  int checkCount = 0;
  int passCount  = 0;

  // producer side
  beat_t                 beatQ[NUM_REQ][$];
  bit                    presenting[NUM_REQ];
  bit                    curValid[NUM_REQ];
  bit                    curLast[NUM_REQ];
  logic [DATA_WIDTH-1:0] curData[NUM_REQ];
  int                    acceptedCount[NUM_REQ];
  int                    gatePct = 100;
  int                    wfullPct = 0;
  bit                    wfullDirected = 1'b0;

  // behavioural model: who owns the port, how many beats it has moved, where the search starts
  int mHolder = -1;
  int mPtr = 0;
  int mBeats = 0;
  int mXferId = -1;
  int mCand;
  bit expGrant;
  bit expWinc;
  int expReady;

  // grant log taken from the DUT outputs and FIFO scoreboards
  int grantIdLog[$];
  int grantBeatLog[$];
  int idleGapLog[$];
  int curBeats = 0;
  int idleRun = 0;
  bit prevGv = 1'b0;
  logic [DATA_WIDTH-1:0] expFifo[$];
  logic [DATA_WIDTH-1:0] dutFifo[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mXferId == i && presenting[i] && beatQ[i].size() > 0) begin
        expFifo.push_back(beatQ[i][0][DATA_WIDTH-1:0]);
        void'(beatQ[i].pop_front());
        presenting[i] = 1'b0;
        acceptedCount[i]++;
      end
      if (!presenting[i] && beatQ[i].size() > 0 && int'($urandom_range(99)) < gatePct) begin
        presenting[i] = 1'b1;
      end
      curValid[i] = presenting[i];
      curData[i]  = presenting[i] ? beatQ[i][0][DATA_WIDTH-1:0] : '0;
      curLast[i]  = presenting[i] ? beatQ[i][0][DATA_WIDTH] : 1'b0;
      bus.req_valid[i] = curValid[i];
      bus.req_last[i]  = curLast[i];
      bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = curData[i];
    end
    bus.fifo_wfull = (wfullPct > 0) ? (int'($urandom_range(99)) < wfullPct) : wfullDirected;
  endtask

  task automatic stepCycle();
    @(posedge wclk);
    #1;
    applyStimulus();
    #1;
  endtask

  task automatic stepUntilAccepted(input int id, input int n, input int budget);
    int cnt = 0;
    while (acceptedCount[id] < n && cnt < budget) begin
      stepCycle();
      cnt++;
    end
    checkOutput("accept_wait_in_budget", int'(acceptedCount[id] >= n), 1);
  endtask

  task automatic resetDut();
    @(posedge wclk);
    #1;
    wrst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      beatQ[i].delete();
      presenting[i]    = 1'b0;
      curValid[i]      = 1'b0;
      curLast[i]       = 1'b0;
      curData[i]       = '0;
      acceptedCount[i] = 0;
    end
    bus.req_valid  = '0;
    bus.req_last   = '0;
    bus.req_data   = '0;
    wfullDirected  = 1'b0;
    wfullPct       = 0;
    gatePct        = 100;
    bus.fifo_wfull = 1'b0;
    #1;
    checkOutput("reset_grant_valid", int'(bus.grant_valid), 0);
    checkOutput("reset_grant_id", int'(bus.grant_id), 0);
    checkOutput("reset_req_ready", int'(bus.req_ready), 0);
    checkOutput("reset_fifo_winc", int'(bus.fifo_winc), 0);
    repeat (2) @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    grantIdLog.delete();
    grantBeatLog.delete();
    idleGapLog.delete();
    expFifo.delete();
    dutFifo.delete();
  endtask

  // Model-vs-DUT comparison on every falling edge, then the model takes the rising-edge decision.
  always @(negedge wclk) begin
    if (!wrst_n) begin
      mHolder = -1;
      mPtr    = 0;
      mBeats  = 0;
      mXferId = -1;
      checkOutput("rst_grant_valid", int'(bus.grant_valid), 0);
      checkOutput("rst_req_ready", int'(bus.req_ready), 0);
      checkOutput("rst_fifo_winc", int'(bus.fifo_winc), 0);
    end else begin
      expGrant = (mHolder >= 0);
      expWinc  = 1'b0;
      expReady = 0;
      if (expGrant) begin
        expWinc = curValid[mHolder] && !bus.fifo_wfull;
        if (!bus.fifo_wfull) expReady = 1 << mHolder;
      end
      checkOutput("grant_valid", int'(bus.grant_valid), int'(expGrant));
      if (expGrant) checkOutput("grant_id", int'(bus.grant_id), mHolder);
      checkOutput("req_ready", int'(bus.req_ready), expReady);
      checkOutput("fifo_winc", int'(bus.fifo_winc), int'(expWinc));
      if (expWinc) checkOutput("fifo_wdata", int'(bus.fifo_wdata), int'(curData[mHolder]));
      checkOutput("winc_while_full", int'(bus.fifo_winc & bus.fifo_wfull), 0);

      mXferId = -1;
      if (mHolder < 0) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          mCand = (mPtr + k) % NUM_REQ;
          if (mHolder < 0 && curValid[mCand]) begin
            mHolder = mCand;
            mBeats  = 0;
          end
        end
      end else if (expWinc) begin
        mXferId = mHolder;
        mBeats++;
        if (curLast[mHolder] || mBeats == MAX_BURST) begin
          mPtr    = (mHolder + 1) % NUM_REQ;
          mHolder = -1;
          mBeats  = 0;
        end
      end else if (!curValid[mHolder]) begin
        mPtr    = (mHolder + 1) % NUM_REQ;
        mHolder = -1;
        mBeats  = 0;
      end
    end
  end

  // Grant history seen at the DUT pins: owner, beats moved, idle cycles before each grant.
  always @(negedge wclk) begin
    if (!wrst_n) begin
      prevGv   = 1'b0;
      curBeats = 0;
      idleRun  = 0;
    end else begin
      if (bus.grant_valid) begin
        if (!prevGv) begin
          grantIdLog.push_back(int'(bus.grant_id));
          idleGapLog.push_back(idleRun);
          curBeats = 0;
        end
        if (bus.fifo_winc) begin
          curBeats++;
          dutFifo.push_back(bus.fifo_wdata);
        end
      end else begin
        if (prevGv) grantBeatLog.push_back(curBeats);
        idleRun = prevGv ? 1 : idleRun + 1;
      end
      prevGv = bus.grant_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mism;
    int burstViolations;
    int cnt;
    bit allEmpty;

    wrst_n         = 1'b0;
    bus.req_valid  = '0;
    bus.req_last   = '0;
    bus.req_data   = '0;
    bus.fifo_wfull = 1'b0;

    // single requester, three beats ending with last
    resetDut();
    beatQ[0].push_back({1'b0, 8'h11});
    beatQ[0].push_back({1'b0, 8'h22});
    beatQ[0].push_back({1'b1, 8'h33});
    stepCycle();
    checkOutput("t1_idle_first", int'(bus.grant_valid), 0);
    stepCycle();
    checkOutput("t1_grant_valid", int'(bus.grant_valid), 1);
    checkOutput("t1_grant_id", int'(bus.grant_id), 0);
    checkOutput("t1_winc0", int'(bus.fifo_winc), 1);
    checkOutput("t1_wdata0", int'(bus.fifo_wdata), 'h11);
    stepCycle();
    checkOutput("t1_winc1", int'(bus.fifo_winc), 1);
    checkOutput("t1_wdata1", int'(bus.fifo_wdata), 'h22);
    stepCycle();
    checkOutput("t1_winc2", int'(bus.fifo_winc), 1);
    checkOutput("t1_wdata2", int'(bus.fifo_wdata), 'h33);
    stepCycle();
    checkOutput("t1_released", int'(bus.grant_valid), 0);
    checkOutput("t1_no_winc", int'(bus.fifo_winc), 0);

    // all requesters busy: round-robin with full bursts and one idle cycle between grants
    resetDut();
    for (int i = 0; i < NUM_REQ; i++)
      for (int s = 0; s < 10; s++) beatQ[i].push_back({1'b0, 2'(i), 6'(s)});
    repeat (30) stepCycle();
    checkOutput("t2_grant_count", int'(grantIdLog.size() >= 5), 1);
    if (grantIdLog.size() >= 5) begin
      checkOutput("t2_order0", grantIdLog[0], 0);
      checkOutput("t2_order1", grantIdLog[1], 1);
      checkOutput("t2_order2", grantIdLog[2], 2);
      checkOutput("t2_order3", grantIdLog[3], 3);
      checkOutput("t2_order4", grantIdLog[4], 0);
      for (int j = 1; j < 5; j++) checkOutput("t2_idle_gap", idleGapLog[j], 1);
    end
    checkOutput("t2_burst_count", int'(grantBeatLog.size() >= 4), 1);
    if (grantBeatLog.size() >= 4)
      for (int j = 0; j < 4; j++) checkOutput("t2_burst_len", grantBeatLog[j], MAX_BURST);

    // full FIFO stalls the burst of requester 1 for five cycles
    resetDut();
    for (int s = 0; s < 4; s++) beatQ[1].push_back({1'b0, 8'hA0 + 8'(s)});
    stepUntilAccepted(1, 2, 20);
    wfullDirected  = 1'b1;
    bus.fifo_wfull = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) stepCycle();
      checkOutput("t3_stall_ready", int'(bus.req_ready), 0);
      checkOutput("t3_stall_winc", int'(bus.fifo_winc), 0);
      checkOutput("t3_stall_gid", int'(bus.grant_id), 1);
      checkOutput("t3_stall_gv", int'(bus.grant_valid), 1);
    end
    wfullDirected = 1'b0;
    stepUntilAccepted(1, 4, 20);
    repeat (3) stepCycle();
    checkOutput("t3_one_grant", grantIdLog.size(), 1);
    checkOutput("t3_beats", (grantBeatLog.size() > 0) ? grantBeatLog[0] : -1, 4);

    // requester 2 drops valid after one beat; pointer then wraps through 3 back to 0
    resetDut();
    beatQ[2].push_back({1'b0, 8'hA2});
    beatQ[3].push_back({1'b1, 8'hB3});
    repeat (5) stepCycle();
    beatQ[0].push_back({1'b1, 8'hC0});
    beatQ[1].push_back({1'b1, 8'hC1});
    repeat (10) stepCycle();
    checkOutput("t4_grant_count", grantIdLog.size(), 4);
    if (grantIdLog.size() == 4) begin
      checkOutput("t4_first", grantIdLog[0], 2);
      checkOutput("t4_second", grantIdLog[1], 3);
      checkOutput("t4_wrap", grantIdLog[2], 0);
      checkOutput("t4_fourth", grantIdLog[3], 1);
      checkOutput("t4_idle_gap", idleGapLog[1], 1);
    end
    checkOutput("t4_short_burst", (grantBeatLog.size() > 0) ? grantBeatLog[0] : -1, 1);

    // reset mid-burst on requester 1
    resetDut();
    for (int s = 0; s < 4; s++) beatQ[1].push_back({1'b0, 8'hD0 + 8'(s)});
    stepUntilAccepted(1, 1, 20);
    checkOutput("t5_busy_before", int'(bus.grant_valid), 1);
    wrst_n = 1'b0;
    #1;
    checkOutput("t5_rst_winc", int'(bus.fifo_winc), 0);
    checkOutput("t5_rst_ready", int'(bus.req_ready), 0);
    checkOutput("t5_rst_gv", int'(bus.grant_valid), 0);
    stepCycle();
    beatQ[0].push_back({1'b0, 8'hE0});
    beatQ[0].push_back({1'b1, 8'hE1});
    stepCycle();
    wrst_n = 1'b1;
    stepCycle();
    checkOutput("t5_after_gv", int'(bus.grant_valid), 1);
    checkOutput("t5_after_gid", int'(bus.grant_id), 0);
    repeat (12) stepCycle();

    // random valid/last/wfull traffic with in-order FIFO scoreboard
    resetDut();
    gatePct  = 60;
    wfullPct = 30;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (beatQ[i].size() < 3)
          beatQ[i].push_back({1'($urandom_range(3) == 0), 8'($urandom)});
      stepCycle();
    end
    gatePct  = 100;
    wfullPct = 0;
    cnt = 0;
    allEmpty = 1'b0;
    while (!allEmpty && cnt < 400) begin
      stepCycle();
      cnt++;
      allEmpty = 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        if (beatQ[i].size() > 0) allEmpty = 1'b0;
    end
    checkOutput("t6_drained", int'(allEmpty), 1);
    repeat (3) stepCycle();
    checkOutput("t6_fifo_beats", dutFifo.size(), expFifo.size());
    mism = 0;
    if (dutFifo.size() == expFifo.size()) begin
      foreach (expFifo[j]) if (dutFifo[j] !== expFifo[j]) mism++;
    end else begin
      mism = 1;
    end
    checkOutput("t6_fifo_order", mism, 0);
    burstViolations = 0;
    foreach (grantBeatLog[j]) if (grantBeatLog[j] > MAX_BURST) burstViolations++;
    checkOutput("t6_burst_limit", burstViolations, 0);
    checkOutput("t6_traffic_seen", int'(expFifo.size() > 100), 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
